// File: rtl/cv32e40s_rf_scrubber_pkg.sv
// Shared types and constants for the register-file ECC scrubber.
// Exports the scrub FSM state type, the register address width and the ISA variant.
package cv32e40s_rf_scrubber_pkg;

  parameter int REGFILE_ADDR_WIDTH = 5;
  parameter int SCRUB_FIRST_ADDR   = 1;

  typedef enum logic [1:0] {
    SCRUB_WAIT,
    SCRUB_SWEEP,
    SCRUB_DONE
  } scrub_state_e;

  typedef enum logic {
    RV32I,
    RV32E
  } rv32_e;

endpackage

// File: rtl/cv32e40s_rf_scrubber_if.sv
// Borrowed register-file read port between the scrubber and the core read mux.
// master: scrub_req/scrub_raddr out, port_gnt/ecc_err in; slave: the mirror.
interface cv32e40s_rf_scrubber_if;
  import cv32e40s_rf_scrubber_pkg::*;

  logic                          scrub_req;
  logic [REGFILE_ADDR_WIDTH-1:0] scrub_raddr;
  logic                          port_gnt;
  logic                          ecc_err;

  modport master (
    output scrub_req,
    output scrub_raddr,
    input  port_gnt,
    input  ecc_err
  );

  modport slave (
    input  scrub_req,
    input  scrub_raddr,
    output port_gnt,
    output ecc_err
  );

endinterface

// File: rtl/cv32e40s_rf_scrubber.sv
// Background ECC scrubber: sweeps x1..x(N-1) on a borrowed read port when idle.
// Ports: clk, rst_n (sync, active-low), scrub_en_i, rf (port if), sweep/alert/error outputs.
module cv32e40s_rf_scrubber
  import cv32e40s_rf_scrubber_pkg::*;
#(
  parameter rv32_e RV32           = RV32I,
  parameter int    SCRUB_INTERVAL = 256,
  parameter int    ERR_CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          scrub_en_i,
  cv32e40s_rf_scrubber_if.master        rf,
  output logic                          sweep_done_o,
  output logic                          alert_o,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o,
  output logic [REGFILE_ADDR_WIDTH-1:0] err_addr_o,
  output logic                          err_addr_valid_o
);

  localparam int AW       = REGFILE_ADDR_WIDTH;
  localparam int NUM_REGS = (RV32 == RV32E) ? 16 : 32;
  localparam int CNT_W    =
    (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  localparam logic [AW-1:0] FIRST = AW'(SCRUB_FIRST_ADDR);
  localparam logic [AW-1:0] LAST  = AW'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(SCRUB_INTERVAL - 1);

  scrub_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic req;
  logic rd_err;
  logic alert_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic [AW-1:0] err_addr_q;
  logic err_valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    req     = 1'b0;
    unique case (state_q)
      SCRUB_WAIT: begin
        if (scrub_en_i) begin
          if (cnt_q == CNT_MAX) begin
            state_d = SCRUB_SWEEP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SCRUB_SWEEP: begin
        req = 1'b1;
        // Disable wins: a granted read this cycle still
        // samples ecc_err, but the sweep is abandoned.
        if (!scrub_en_i) begin
          state_d = SCRUB_WAIT;
          raddr_d = FIRST;
        end else if (rf.port_gnt) begin
          if (raddr_q == LAST) begin
            state_d = SCRUB_DONE;
            raddr_d = FIRST;
          end else begin
            raddr_d = raddr_q + AW'(1);
          end
        end
      end
      SCRUB_DONE: begin
        state_d = SCRUB_WAIT;
      end
      default: begin
        state_d = SCRUB_WAIT;
      end
    endcase
  end

  assign rd_err = req & rf.port_gnt & rf.ecc_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SCRUB_WAIT;
      cnt_q       <= '0;
      raddr_q     <= FIRST;
      alert_q     <= 1'b0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      alert_q <= rd_err;
      if (rd_err) begin
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
        end
        if (!err_valid_q) begin
          err_addr_q  <= raddr_q;
          err_valid_q <= 1'b1;
        end
      end
    end
  end

  assign rf.scrub_req      = req;
  assign rf.scrub_raddr    = raddr_q;
  assign sweep_done_o      = (state_q == SCRUB_DONE);
  assign alert_o           = alert_q;
  assign err_cnt_o         = err_cnt_q;
  assign err_addr_o        = err_addr_q;
  assign err_addr_valid_o  = err_valid_q;

endmodule

// File: tb/tb_cv32e40s_rf_scrubber.sv
// Bench for the RF scrubber: RV32I (width-2 counter) and RV32E instances.
// Scenario table, a hand sequence and random traffic against a reference model.
module tb_cv32e40s_rf_scrubber;
  import cv32e40s_rf_scrubber_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en    = 1'b0;

  cv32e40s_rf_scrubber_if ifa();
  cv32e40s_rf_scrubber_if ifb();

  logic       done_a, alert_a, fv_a;
  logic [1:0] cnt_a;
  logic [4:0] faddr_a;
  logic       done_b, alert_b, fv_b;
  logic [7:0] cnt_b;
  logic [4:0] faddr_b;

  cv32e40s_rf_scrubber #(
    .RV32(RV32I), .SCRUB_INTERVAL(4), .ERR_CNT_WIDTH(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .scrub_en_i(en), .rf(ifa),
    .sweep_done_o(done_a), .alert_o(alert_a),
    .err_cnt_o(cnt_a), .err_addr_o(faddr_a),
    .err_addr_valid_o(fv_a)
  );

  cv32e40s_rf_scrubber #(
    .RV32(RV32E), .SCRUB_INTERVAL(4), .ERR_CNT_WIDTH(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .scrub_en_i(en), .rf(ifb),
    .sweep_done_o(done_b), .alert_o(alert_b),
    .err_cnt_o(cnt_b), .err_addr_o(faddr_b),
    .err_addr_valid_o(fv_b)
  );

  int n_tot  = 0;
  int n_pass = 0;
  bit checking = 0;

  // Reference model: index 0 = RV32I/cnt max 3, index 1 = RV32E/cnt max 255.
  int p_nregs[2] = '{32, 16};
  int p_cmax[2]  = '{3, 255};
  localparam int INTERVAL = 4;
  int m_mode[2];
  int m_idle[2];
  int m_addr[2];
  int m_cnt[2];
  int m_faddr[2];
  int m_fv[2];
  int m_alert[2];

  // Observed DUT A values at the latest sample point.
  int t_req, t_done, t_alert;
  int l_req, l_raddr, l_cnt, l_faddr, l_fv;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void mdl(input int m, input bit rst,
                              input bit e, input bit g, input bit er);
    bit rd;
    if (rst) begin
      m_mode[m] = 0; m_idle[m] = 0; m_addr[m] = 1;
      m_cnt[m] = 0; m_faddr[m] = 0; m_fv[m] = 0; m_alert[m] = 0;
      return;
    end
    rd = (m_mode[m] == 1) && g;
    m_alert[m] = (rd && er) ? 1 : 0;
    if (m_alert[m] == 1) begin
      if (m_cnt[m] < p_cmax[m]) m_cnt[m]++;
      if (m_fv[m] == 0) begin
        m_faddr[m] = m_addr[m];
        m_fv[m] = 1;
      end
    end
    case (m_mode[m])
      0: if (e) begin
        if (m_idle[m] == INTERVAL - 1) begin
          m_mode[m] = 1; m_idle[m] = 0;
        end else m_idle[m]++;
      end
      1: if (!e) begin
        m_mode[m] = 0; m_addr[m] = 1;
      end else if (g) begin
        if (m_addr[m] == p_nregs[m] - 1) begin
          m_mode[m] = 2; m_addr[m] = 1;
        end else m_addr[m]++;
      end
      default: m_mode[m] = 0;
    endcase
  endfunction

  task automatic cmp(input string p, input int m,
                     input logic req, input logic [4:0] ra,
                     input logic dn, input logic al,
                     input logic [7:0] cn, input logic [4:0] fa,
                     input logic fv);
    chk({p, "req"},   int'(req), (m_mode[m] == 1) ? 1 : 0);
    chk({p, "raddr"}, int'(ra),  m_addr[m]);
    chk({p, "done"},  int'(dn),  (m_mode[m] == 2) ? 1 : 0);
    chk({p, "alert"}, int'(al),  m_alert[m]);
    chk({p, "cnt"},   int'(cn),  m_cnt[m]);
    chk({p, "faddr"}, int'(fa),  m_faddr[m]);
    chk({p, "fvalid"}, int'(fv), m_fv[m]);
  endtask

  task automatic step(input bit rst, input bit e, input bit g,
                      input bit ea, input bit eb);
    @(negedge clk);
    if (checking) begin
      cmp("a_", 0, ifa.scrub_req, ifa.scrub_raddr, done_a,
          alert_a, {6'd0, cnt_a}, faddr_a, fv_a);
      cmp("b_", 1, ifb.scrub_req, ifb.scrub_raddr, done_b,
          alert_b, cnt_b, faddr_b, fv_b);
    end
    l_req = int'(ifa.scrub_req);
    l_raddr = int'(ifa.scrub_raddr);
    l_cnt = int'(cnt_a);
    l_faddr = int'(faddr_a);
    l_fv = int'(fv_a);
    t_req += l_req;
    t_done += int'(done_a);
    t_alert += int'(alert_a);
    rst_n = !rst;
    en = e;
    ifa.port_gnt = g; ifb.port_gnt = g;
    ifa.ecc_err = ea; ifb.ecc_err = eb;
    mdl(0, rst, e, g, ea);
    mdl(1, rst, e, g, eb);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    checking = 1;
    t_req = 0; t_done = 0; t_alert = 0;
  endtask

  typedef struct {
    int          gnt_mode;   // 0: always, 1: odd cycles, 2: never
    logic [31:0] mask;       // addresses that report an ECC error
    int          drop_at;
    int          drop_len;
    int          cycles;
    int          e_done;
    int          e_alert;
    int          e_cnt;
    int          e_faddr;
    int          e_fv;
    int          e_req;
  } vec_t;

  vec_t vt[5];

  initial begin
    bit e, g;
    int n;
    ifa.port_gnt = 0; ifa.ecc_err = 0;
    ifb.port_gnt = 0; ifb.ecc_err = 0;

    vt[0] = '{0, 32'h0000_0000, -1, 0, 40, 1, 0, 0, 0, 0, 31};
    vt[1] = '{1, 32'h0000_0220, -1, 0, 70, 1, 2, 2, 5, 1, 62};
    vt[2] = '{0, 32'h0000_003E, -1, 0, 40, 1, 5, 3, 1, 1, 31};
    vt[3] = '{0, 32'h0000_1000, 15, 5, 35, 0, 1, 1, 12, 1, 23};
    vt[4] = '{2, 32'hFFFF_FFFF, -1, 0, 30, 0, 0, 0, 0, 0, 26};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      for (int c = 0; c < vt[i].cycles; c++) begin
        e = !(vt[i].drop_at >= 0 && c >= vt[i].drop_at &&
              c < vt[i].drop_at + vt[i].drop_len);
        case (vt[i].gnt_mode)
          0: g = 1'b1;
          1: g = (c % 2) == 1;
          default: g = 1'b0;
        endcase
        step(0, e, g, vt[i].mask[m_addr[0]], vt[i].mask[m_addr[1]]);
      end
      chk($sformatf("v%0d_done", i), t_done, vt[i].e_done);
      chk($sformatf("v%0d_alert", i), t_alert, vt[i].e_alert);
      chk($sformatf("v%0d_cnt", i), l_cnt, vt[i].e_cnt);
      chk($sformatf("v%0d_faddr", i), l_faddr, vt[i].e_faddr);
      chk($sformatf("v%0d_fvalid", i), l_fv, vt[i].e_fv);
      chk($sformatf("v%0d_reqcyc", i), t_req, vt[i].e_req);
    end

    // Hand sequence: request latency, address held without grant.
    do_reset();
    n = 0;
    step(0, 1, 0, 0, 0);
    while (l_req == 0 && n < 20) begin
      n++;
      step(0, 1, 0, 0, 0);
    end
    chk("wait_to_req", n, 4);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0);
      chk("hold_raddr", l_raddr, 1);
    end
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("adv_raddr", l_raddr, 2);

    // Random traffic, including occasional mid-sweep resets.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      step(($urandom % 300) == 0,
           ($urandom % 25) != 0,
           ($urandom % 10) < 7,
           ($urandom % 12) == 0,
           ($urandom % 12) == 0);
    end
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
